add_restore: RTL
================

// Module: add_restore
// PURPOSE
//  Inverse of the registered subtractor stage: rebuilds an unsigned sample stream
//  from signed differences (diff = a - b). It holds a running value acc, seeded
//  with a base sample, and on each accepted difference emits acc + diff.
//  Sits downstream of the difference pipeline, with valid/ready handshakes on both sides.
// PARAMETERS
//  DW        4       unsigned sample width (acc, seed_data, out_data)
//  DDW       DW+1    signed difference width (diff_data); fixed, do not override
//  ERRW      8       width of saturating error counter err_cnt
// PORTS
//  clk         in   1     clock, rising edge
//  rst_n       in   1     reset, asynchronous, active-high
//  seed_valid  in   1     load seed_data as new base value (1-cycle strobe)
//  seed_data   in   DW    unsigned base sample
//  diff_valid  in   1     difference present
//  diff_ready  out  1     block accepts difference this cycle
//  diff_data   in   DDW   signed difference, two's complement
//  out_valid   out  1     out_data holds a reconstructed sample
//  out_ready   in   1     downstream accepts out_data
//  out_data    out  DW    reconstructed unsigned sample
//  out_sat     out  1     current out_data was clamped
//  err_sticky  out  1     any clamp since last seed/reset
//  err_cnt     out  ERRW  count of clamped samples, saturates at 2^ERRW-1
//  seeded      out  1     high in RUN state
// BEHAVIOUR
//  Reset (clk and rst_n=1): state=IDLE, acc=0, out_valid=0, out_data=0, out_sat=0,
//   err_sticky=0, err_cnt=0, seeded=0. A reset during a transfer drops pending output.
//  FSM: IDLE -seed_valid-> RUN. In RUN, seed_valid re-seeds and stays in RUN.
//   No other transitions; only reset returns to IDLE.
//  Seed: acc<=seed_data and err_sticky<=0 on the next edge. seed_valid produces
//   no output, and out_valid/out_data are left unchanged.
//  diff_ready = (state==RUN) & ~seed_valid & (~out_valid | out_ready).
//   Seed has priority over a difference in the same cycle; the difference is not
//   taken and the source must hold it.
//  Accept (diff_valid & diff_ready): sum = {2'b0,acc} + sign-extended diff_data,
//   computed in DW+2 bits. If sum<0: result=0 and sat=1.
//   If sum>2^DW-1: result=2^DW-1 and sat=1. Otherwise result=sum and sat=0.
//   Next edge: acc<=result, out_data<=result, out_sat<=sat, out_valid<=1.
//   If sat: err_sticky<=1 and err_cnt+=1 (saturating).
//  Latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle while out_ready=1.
//  Output: out_valid falls when out_ready=1 and no new accept occurs.
//   Accept and drain in the same cycle gives back-to-back samples.
//   While out_valid=1 and out_ready=0, out_data and out_sat are held stable.
//  Differences arriving in IDLE are never accepted (diff_ready=0).
//  acc is the clamped value, so saturation does not accumulate error.
// TESTING (DW=4)
//  1 Reset, then seed 5 and diffs +3,-2,+0 with out_ready=1
//    -> out 8,6,6; out_sat=0, one sample per cycle.
//  2 Seed 14, diff +5 -> out 15, out_sat=1, err_cnt=1. Then diff -16 -> out 0,
//    out_sat=1, err_cnt=2, err_sticky=1. Then seed 3 -> err_sticky=0, err_cnt=2.
//  3 Seed 7, diffs +1,+1,+1 with out_ready low for 3 cycles -> out_data=8 held,
//    diff_ready=0. On release -> 9,10 follow with no loss.
//  4 In RUN, seed_valid=1 (seed 2) and diff_valid=1 (+4) together -> diff not taken.
//    Next cycle it is taken -> out 6.
//  5 diff_valid with no seed after reset -> diff_ready=0, out_valid=0 for 10 cycles.
//  6 Raise rst_n while out_valid=1 and out_ready=0 -> out_valid=0, err_cnt=0,
//    seeded=0 immediately (asynchronous).

Source files
------------

// File: rtl/add_restore.sv
// add_restore
//   Rebuilds an unsigned sample stream from signed differences (diff = a - b).
//   A running value acc is seeded with a base sample. Each accepted difference
//   produces the sample acc + diff, clamped to [0, 2^DW-1]. The clamped value
//   becomes the new acc.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous reset, active-high
//   seed_valid  load seed_data as the new base value (1-cycle strobe)
//   seed_data   unsigned base sample, DW bits
//   diff_valid  difference present
//   diff_ready  difference accepted this cycle
//   diff_data   signed two's-complement difference, DDW bits
//   out_valid   out_data holds a reconstructed sample
//   out_ready   downstream accepts out_data
//   out_data    reconstructed unsigned sample, DW bits
//   out_sat     current out_data was clamped
//   err_sticky  any clamp since the last seed or reset
//   err_cnt     saturating count of clamped samples, ERRW bits
//   seeded      high once a seed has been taken (RUN state)
module add_restore #(
  parameter int DW   = 4,
  parameter int ERRW = 8,
  localparam int DDW = DW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            seed_valid,
  input  logic [DW-1:0]   seed_data,
  input  logic            diff_valid,
  output logic            diff_ready,
  input  logic [DDW-1:0]  diff_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_sat,
  output logic            err_sticky,
  output logic [ERRW-1:0] err_cnt,
  output logic            seeded
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   acc;
  logic [DW+1:0]   sum;
  logic [DW-1:0]   result;
  logic            sat;
  logic            accept;

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake and clamped sum
  always_comb begin
    state_nxt  = state;
    diff_ready = 1'b0;
    seeded     = 1'b0;
    result     = '0;
    sat        = 1'b0;

    case (state)
      IDLE: begin
        if (seed_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        seeded     = 1'b1;
        // A seed in the same cycle wins; the source must hold its difference.
        diff_ready = ~seed_valid & (~out_valid | out_ready);
      end
      default: state_nxt = IDLE;
    endcase

    // Two extra bits: bit DW+1 flags a negative sum, bit DW an overflow.
    sum = {2'b00, acc} + {diff_data[DDW-1], diff_data};
    if (sum[DW+1]) begin
      result = '0;
      sat    = 1'b1;
    end else if (sum[DW]) begin
      result = '1;
      sat    = 1'b1;
    end else begin
      result = sum[DW-1:0];
    end
  end

  assign accept = diff_valid & diff_ready;

  // Accumulator, output register and error tracking
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (seed_valid) begin
        acc        <= seed_data;
        err_sticky <= 1'b0;
      end else if (accept) begin
        acc <= result;
        if (sat) begin
          err_sticky <= 1'b1;
        end
      end

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_sat   <= sat;
        if (sat && (err_cnt != '1)) begin
          err_cnt <= err_cnt + {{(ERRW-1){1'b0}}, 1'b1};
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
